// File: rtl/ahb_apb_pkg.sv
// Shared types and bus encodings for the parametrised AHB-Lite to APB3 bridge.
// Bridge FSM states, HTRANS codes and HRESP values.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        RESP,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    function automatic logic is_accept_state(input state_t s);
        return (s == IDLE) || (s == RESP) || (s == ERR2);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB window decoder: maps HADDR onto contiguous equal-size slave windows.
// Zero latency; no flow control.
module apb_addr_decoder #(
    parameter int              ADDR_W        = 32,
    parameter int              NUM_SLV       = 3,
    parameter logic [ADDR_W-1:0] SLV_BASE    = 32'h8000_0000,
    parameter int              SLV_SIZE_LOG2 = 12
) (
    input  logic [ADDR_W-1:0]  haddr,
    output logic               hit,
    output logic [NUM_SLV-1:0] sel
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;

    always_comb begin
        off = haddr - SLV_BASE;
        idx = off >> SLV_SIZE_LOG2;
        hit = (haddr >= SLV_BASE) && (idx < ADDR_W'(NUM_SLV));
        sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = hit && (idx == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite slave to APB3 master bridge, one outstanding transfer, all outputs registered.
// Latency: SETUP two cycles after the address phase, RESP after the PREADY cycle; AHB is held
// with HREADY_OUT low until APB completes. Optional ACCESS timeout under APB_TIMEOUT_EN.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter int                NUM_SLV       = 3,
    parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
    parameter int                SLV_SIZE_LOG2 = 12,
    parameter int                TIMEOUT_CYC   = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [1:0]         HTRANS,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic               HWRITE,
    input  logic [DATA_W-1:0]  HWDATA,
    input  logic               HREADYin,
    output logic               HREADY_OUT,
    output logic [1:0]         HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [NUM_SLV-1:0] PSELx,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    state_t               state_q, state_d;
    logic                 hit_q, hit_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [DATA_W-1:0]    hrdata_q, hrdata_d;
    logic                 hready_q, hready_d;
    logic [1:0]           hresp_q, hresp_d;

    logic                 dec_hit;
    logic [NUM_SLV-1:0]   dec_sel;
    logic                 accept;
    logic                 tmo_hit;
    logic                 htrans_seq_unused;

    assign htrans_seq_unused = HTRANS[0];

    apb_addr_decoder #(
        .ADDR_W        (ADDR_W),
        .NUM_SLV       (NUM_SLV),
        .SLV_BASE      (SLV_BASE),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_dec (
        .haddr (HADDR),
        .hit   (dec_hit),
        .sel   (dec_sel)
    );

`ifdef APB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero whenever not in ACCESS, so it starts clean on every entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ACCESS && !PREADY) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_cnt_q == TMO_LAST);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [31:0] tmo_cfg_unused;
    assign tmo_cfg_unused = 32'(TIMEOUT_CYC);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        sel_d    = sel_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        accept = HSEL && HREADYin && HTRANS[1] && is_accept_state(state_q);

        case (state_q)
            IDLE:    if (accept) state_d = LATCH;
            LATCH: begin
                if (pwrite_q) pwdata_d = HWDATA;
                state_d = hit_q ? SETUP : ERR1;
            end
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ERR1 : RESP;
                    if (!pwrite_q) hrdata_d = PRDATA;
                end else if (tmo_hit) begin
                    state_d = ERR1;
                end
            end
            RESP:    state_d = accept ? LATCH : IDLE;
            ERR1:    state_d = ERR2;
            ERR2:    state_d = accept ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase

        // Address-phase capture; PADDR may move while PSELx is low, it is stable from SETUP on.
        if (accept) begin
            hit_d    = dec_hit;
            sel_d    = dec_sel;
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
        end

        hready_d  = is_accept_state(state_d);
        hresp_d   = (state_d == ERR1 || state_d == ERR2) ? HRESP_ERROR : HRESP_OKAY;
        psel_d    = (state_d == SETUP || state_d == ACCESS) ? sel_q : '0;
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            hit_q     <= 1'b0;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            sel_q     <= sel_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
        end
    end

    assign HREADY_OUT = hready_q;
    assign HRESP      = hresp_q;
    assign HRDATA     = hrdata_q;
    assign PSELx      = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Randomised and directed bench for ahb_apb_bridge_p against a transaction-level reference model.
// Honours APB_TIMEOUT_EN for the stuck-PREADY scenario.
module tb_ahb_apb_bridge_p;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic        HREADY_OUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [2:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] hr_model = '0;

    always #5 HCLK = ~HCLK;

    // Single AHB slave on the bus: the bus-wide HREADY is the bridge's own.
    assign HREADYin = HREADY_OUT;

    ahb_apb_bridge_p #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .NUM_SLV       (3),
        .SLV_BASE      (32'h8000_0000),
        .SLV_SIZE_LOG2 (12),
        .TIMEOUT_CYC   (16)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADYin   (HREADYin),
        .HREADY_OUT (HREADY_OUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        repeat (n) step();
    endtask

    task automatic reset_pulse();
        HRESETn = 1'b0;
        step();
        check("rst_psel",   PSELx,      3'b000);
        check("rst_pen",    PENABLE,    1'b0);
        check("rst_pwrite", PWRITE,     1'b0);
        check("rst_paddr",  PADDR,      32'h0);
        check("rst_pwdata", PWDATA,     32'h0);
        check("rst_hrdata", HRDATA,     32'h0);
        check("rst_hready", HREADY_OUT, 1'b1);
        check("rst_hresp",  HRESP,      2'b00);
        HRESETn  = 1'b1;
        hr_model = '0;
    endtask

    // One AHB transfer with a scripted APB slave; entered and left in a ready cycle so
    // consecutive calls issue back-to-back address phases.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int nwait, input logic serr, input logic [31:0] rdata);
        logic        hit;
        int          idx;
        logic [2:0]  esel;
        int          exp_low;
        logic        exp_err;
        int          low, c, setup_c, acc_n, waits_left;
        logic [2:0]  psel_seen;
        logic [31:0] paddr_seen, pwdata_seen;
        logic        pwrite_seen, stable;
        logic [1:0]  prev_resp;

        hit  = (addr >= BASE) && (((addr - BASE) >> 12) < 32'd3);
        idx  = hit ? int'((addr - BASE) >> 12) : 0;
        esel = hit ? 3'(1 << idx) : 3'b000;
        exp_err = !hit || serr;
        exp_low = !hit ? 2 : (serr ? 4 + nwait : 3 + nwait);

        check("addr_phase_rdy", HREADY_OUT, 1'b1);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata; PRDATA = rdata;

        low = 0; c = 1; setup_c = 0; acc_n = 0; waits_left = nwait;
        psel_seen = '0; paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 1'b0;
        stable = 1'b1; prev_resp = 2'b00;
        while (HREADY_OUT == 1'b0 && c < 64) begin
            if (PSELx != 3'b000 && !PENABLE) begin
                if (setup_c == 0) setup_c = c;
                psel_seen = PSELx; paddr_seen = PADDR; pwrite_seen = PWRITE; pwdata_seen = PWDATA;
            end
            PSLVERR = 1'b0;
            PREADY  = 1'b1;
            if (PENABLE) begin
                acc_n++;
                if (PSELx != psel_seen || PADDR != paddr_seen || PWRITE != pwrite_seen ||
                    PWDATA != pwdata_seen) stable = 1'b0;
                if (waits_left > 0) begin
                    PREADY = 1'b0;
                    waits_left--;
                end else begin
                    PSLVERR = serr;
                end
            end
            prev_resp = HRESP;
            low++;
            step();
            c++;
        end
        PREADY  = 1'b1;
        PSLVERR = 1'b0;

        if (hit && !wr && !serr) hr_model = rdata;
        check("wait_cycles", low, exp_low);
        check("final_resp", HRESP, exp_err ? 2'b01 : 2'b00);
        if (exp_err) check("err1_resp", prev_resp, 2'b01);
        if (hit) begin
            check("setup_cycle", setup_c, 2);
            check("psel",        psel_seen, esel);
            check("paddr",       paddr_seen, addr);
            check("pwrite",      pwrite_seen, wr);
            check("access_cyc",  acc_n, nwait + 1);
            check("apb_stable",  stable, 1'b1);
            if (wr) check("pwdata", pwdata_seen, wdata);
        end else begin
            check("miss_psel",   psel_seen, 3'b000);
            check("miss_access", acc_n, 0);
        end
        check("hrdata", HRDATA, hr_model);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, acc;
        logic [31:0] a;
        int s;
        logic wr;

        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HWDATA = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        repeat (2) step();
        reset_pulse();
        idle(1);

        do_xfer(32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        idle(1);
        do_xfer(32'h8000_2008, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
        idle(2);
        do_xfer(32'h8000_3000, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
        idle(1);
        do_xfer(32'h8000_0000, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h0);
        do_xfer(32'h8000_1008, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_0001);
        do_xfer(32'h8000_0010, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0);
        do_xfer(32'h8000_2010, 1'b1, 32'h3333_4444, 0, 1'b0, 32'h0);
        idle(1);

        // Reset asserted while the APB slave is stalling in ACCESS.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h8000_1010; HWRITE = 1'b1;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hA5A5_5A5A; PREADY = 1'b0;
        c = 0;
        while (!PENABLE && c < 10) begin step(); c++; end
        check("rst_in_access", PENABLE, 1'b1);
        reset_pulse();
        PREADY = 1'b1;
        idle(3);
        check("no_retry_psel", PSELx, 3'b000);

        for (int i = 0; i < 40; i++) begin
            s  = $urandom_range(0, 5);
            a  = {20'h0, $urandom_range(0, 1023) * 4};
            wr = 1'($urandom_range(0, 1));
            case (s)
                4:       a = 32'h7FFF_F000 + a;
                5:       a = 32'hFFFF_0000 + a;
                default: a = BASE + (32'(s) << 12) + a;
            endcase
            do_xfer(a, wr, $urandom, $urandom_range(0, 3),
                    wr && ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        // PREADY stuck low.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h8000_0100; HWRITE = 1'b0;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
        c = 0; acc = 0;
`ifdef APB_TIMEOUT_EN
        while (c < 200 && !(acc > 0 && !PENABLE)) begin
            if (PENABLE) acc++;
            step(); c++;
        end
        check("tmo_access_cyc", acc, 16);
        check("tmo_psel",       PSELx, 3'b000);
        check("tmo_err1_rdy",   HREADY_OUT, 1'b0);
        check("tmo_err1_resp",  HRESP, 2'b01);
        step();
        check("tmo_err2_rdy",   HREADY_OUT, 1'b1);
        check("tmo_err2_resp",  HRESP, 2'b01);
        check("tmo_hrdata",     HRDATA, hr_model);
        PREADY = 1'b1;
        idle(1);
`else
        while (c < 300 && acc < 100) begin
            if (PENABLE) acc++;
            step(); c++;
        end
        check("stuck_access_cyc", acc, 100);
        check("stuck_penable",    PENABLE, 1'b1);
        check("stuck_hready",     HREADY_OUT, 1'b0);
        check("stuck_psel",       PSELx, 3'b001);
        reset_pulse();
        PREADY = 1'b1;
        idle(1);
`endif
        do_xfer(32'h8000_2000, 1'b0, 32'h0, 0, 1'b0, 32'h7777_8888);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
